// File: rtl/time_setter.sv
// time_setter: pushbutton front end that edits and loads the time counter.
// Debounces mode/up/down, steps hours/minutes/seconds edit states.
module time_setter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int TIMEOUT_CYCLES  = 1000000000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [5:0] curr_hours,
  input  logic [6:0] curr_minutes,
  input  logic [6:0] curr_seconds,
  output logic       hold,
  output logic [1:0] edit_field,
  output logic [5:0] edit_hours,
  output logic [6:0] edit_minutes,
  output logic [6:0] edit_seconds,
  output logic       load_stb,
  output logic [5:0] load_hours,
  output logic [6:0] load_minutes,
  output logic [6:0] load_seconds
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RMAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_V    = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RR_V    = RW'(REPEAT_RATE);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RUN, S_SET_H, S_SET_M, S_SET_S, S_COMMIT
  } state_t;

  state_t r_state;
  state_t w_next;

  // bit 0 = mode, bit 1 = up, bit 2 = down
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_db;
  logic [2:0]    r_db_q;
  logic [2:0]    r_blk;
  logic [DW-1:0] r_dbcnt [3];
  logic [2:0]    w_rise;

  // index 0 = up, 1 = down
  logic [RW-1:0] r_rcnt [2];
  logic [1:0]    r_rph;
  logic [1:0]    w_rep;

  logic          w_ev_mode;
  logic          w_ev_up;
  logic          w_ev_dn;
  logic          w_any;
  logic          w_inc;
  logic          w_dec;
  logic          w_in_set;
  logic          w_tout;
  logic [TW-1:0] r_tcnt;

  logic [5:0]    r_eh;
  logic [6:0]    r_em;
  logic [6:0]    r_es;
  logic [5:0]    r_lh;
  logic [6:0]    r_lm;
  logic [6:0]    r_ls;

  function automatic logic [6:0] wrap_inc(
    input logic [6:0] v, input logic [6:0] mx);
    return (v >= mx) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [6:0] wrap_dec(
    input logic [6:0] v, input logic [6:0] mx);
    return (v == 7'd0 || v > mx) ? mx : v - 7'd1;
  endfunction

  // Two-flop synchronizers for the raw buttons
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {btn_down, btn_up, btn_mode};
      r_sync2 <= r_sync1;
    end
  end

  // Debounce; r_blk swallows a press that was held through reset
  // until a stable-low period has been observed
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_db   <= '0;
      r_db_q <= '0;
      r_blk  <= '1;
      for (int i = 0; i < 3; i++) r_dbcnt[i] <= '0;
    end else begin
      r_db_q <= r_db;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_dbcnt[i] == DB_LAST) begin
            r_db[i]    <= r_sync2[i];
            r_dbcnt[i] <= '0;
          end else begin
            r_dbcnt[i] <= r_dbcnt[i] + DW'(1);
          end
        end else if (r_blk[i] && !r_db[i]) begin
          if (r_dbcnt[i] == DB_LAST) begin
            r_blk[i]   <= 1'b0;
            r_dbcnt[i] <= '0;
          end else begin
            r_dbcnt[i] <= r_dbcnt[i] + DW'(1);
          end
        end else begin
          r_dbcnt[i] <= '0;
        end
      end
    end
  end

  assign w_rise = r_db & ~r_db_q & ~r_blk;

  assign w_rep[0] = r_db[1] & ~r_blk[1] &
    (r_rph[0] ? (r_rcnt[0] == RR_V) : (r_rcnt[0] == RD_V));
  assign w_rep[1] = r_db[2] & ~r_blk[2] &
    (r_rph[1] ? (r_rcnt[1] == RR_V) : (r_rcnt[1] == RD_V));

  // Auto-repeat timers for up/down, cleared on release
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_rph <= '0;
      for (int k = 0; k < 2; k++) r_rcnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!r_db[k+1] || r_blk[k+1]) begin
          r_rcnt[k] <= '0;
          r_rph[k]  <= 1'b0;
        end else if (w_rep[k]) begin
          r_rcnt[k] <= RW'(1);
          r_rph[k]  <= 1'b1;
        end else begin
          r_rcnt[k] <= r_rcnt[k] + RW'(1);
        end
      end
    end
  end

  assign w_ev_mode = w_rise[0];
  assign w_ev_up   = w_rise[1] | w_rep[0];
  assign w_ev_dn   = w_rise[2] | w_rep[1];
  assign w_any     = w_ev_mode | w_ev_up | w_ev_dn;
  assign w_inc     = w_ev_up & ~w_ev_dn & ~w_ev_mode;
  assign w_dec     = w_ev_dn & ~w_ev_up & ~w_ev_mode;
  assign w_in_set  = (r_state == S_SET_H) || (r_state == S_SET_M) ||
                     (r_state == S_SET_S);
  assign w_tout    = w_in_set && (r_tcnt == TO_LAST);

  // Idle timer that aborts an abandoned edit
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (!w_in_set || w_any) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end

  // State register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN:    if (w_ev_mode) w_next = S_SET_H;
      S_SET_H:  if (w_ev_mode) w_next = S_SET_M;
                else if (w_tout) w_next = S_RUN;
      S_SET_M:  if (w_ev_mode) w_next = S_SET_S;
                else if (w_tout) w_next = S_RUN;
      S_SET_S:  if (w_ev_mode) w_next = S_COMMIT;
                else if (w_tout) w_next = S_RUN;
      S_COMMIT: w_next = S_RUN;
      default:  w_next = S_RUN;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    hold       = 1'b0;
    edit_field = 2'd0;
    load_stb   = 1'b0;
    case (r_state)
      S_SET_H:  begin hold = 1'b1; edit_field = 2'd1; end
      S_SET_M:  begin hold = 1'b1; edit_field = 2'd2; end
      S_SET_S:  begin hold = 1'b1; edit_field = 2'd3; end
      S_COMMIT: load_stb = 1'b1;
      default:  ;
    endcase
  end

  // Edit registers: snapshot on entry, then step the active field
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_eh <= '0;
      r_em <= '0;
      r_es <= '0;
    end else if (r_state == S_RUN && w_ev_mode) begin
      r_eh <= (curr_hours > 6'd23)   ? 6'd0 : curr_hours;
      r_em <= (curr_minutes > 7'd59) ? 7'd0 : curr_minutes;
      r_es <= (curr_seconds > 7'd59) ? 7'd0 : curr_seconds;
    end else begin
      case (r_state)
        S_SET_H: begin
          if (w_inc) r_eh <= 6'(wrap_inc({1'b0, r_eh}, 7'd23));
          if (w_dec) r_eh <= 6'(wrap_dec({1'b0, r_eh}, 7'd23));
        end
        S_SET_M: begin
          if (w_inc) r_em <= wrap_inc(r_em, 7'd59);
          if (w_dec) r_em <= wrap_dec(r_em, 7'd59);
        end
        S_SET_S: begin
          if (w_inc) r_es <= wrap_inc(r_es, 7'd59);
          if (w_dec) r_es <= wrap_dec(r_es, 7'd59);
        end
        default: ;
      endcase
    end
  end

  // Load values captured on entry to COMMIT and kept afterwards
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_lh <= '0;
      r_lm <= '0;
      r_ls <= '0;
    end else if (r_state == S_SET_S && w_ev_mode) begin
      r_lh <= r_eh;
      r_lm <= r_em;
      r_ls <= r_es;
    end
  end

  assign edit_hours   = r_eh;
  assign edit_minutes = r_em;
  assign edit_seconds = r_es;
  assign load_hours   = r_lh;
  assign load_minutes = r_lm;
  assign load_seconds = r_ls;

endmodule

// File: tb/tb_time_setter.sv
// tb_time_setter: directed bench for time_setter.
// Expected loads are queued at stimulus time and matched on load_stb.
module tb_time_setter;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [5:0] curr_hours;
  logic [6:0] curr_minutes;
  logic [6:0] curr_seconds;
  logic       hold;
  logic [1:0] edit_field;
  logic [5:0] edit_hours;
  logic [6:0] edit_minutes;
  logic [6:0] edit_seconds;
  logic       load_stb;
  logic [5:0] load_hours;
  logic [6:0] load_minutes;
  logic [6:0] load_seconds;

  time_setter #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (5),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .btn_mode     (btn_mode),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .curr_hours   (curr_hours),
    .curr_minutes (curr_minutes),
    .curr_seconds (curr_seconds),
    .hold         (hold),
    .edit_field   (edit_field),
    .edit_hours   (edit_hours),
    .edit_minutes (edit_minutes),
    .edit_seconds (edit_seconds),
    .load_stb     (load_stb),
    .load_hours   (load_hours),
    .load_minutes (load_minutes),
    .load_seconds (load_seconds)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int h;
    int m;
    int s;
  } ld_t;

  ld_t q[$];
  int  n_pass = 0;
  int  n_total = 0;
  int  n_fail = 0;
  int  n_stb = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic press(input bit m, input bit u, input bit d);
    if (m) btn_mode = 1'b1;
    if (u) btn_up = 1'b1;
    if (d) btn_down = 1'b1;
    step(10);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    step(10);
  endtask

  task automatic set_curr(input int h, input int m, input int s);
    curr_hours   = 6'(h);
    curr_minutes = 7'(m);
    curr_seconds = 7'(s);
  endtask

  always @(negedge sys_clk) begin
    if (load_stb === 1'b1) begin
      ld_t e;
      n_stb++;
      if (q.size() == 0) begin
        chk("unexpected_load_stb", 32'(load_stb), 0);
      end else begin
        e = q.pop_front();
        chk("load_hours", 32'(load_hours), e.h);
        chk("load_minutes", 32'(load_minutes), e.m);
        chk("load_seconds", 32'(load_seconds), e.s);
        chk("hold_in_commit", 32'(hold), 0);
        chk("field_in_commit", 32'(edit_field), 0);
      end
    end
  end

  initial begin
    set_curr(12, 34, 56);
    #2;
    chk("rst_hold", 32'(hold), 0);
    chk("rst_field", 32'(edit_field), 0);
    chk("rst_edit_h", 32'(edit_hours), 0);
    chk("rst_edit_m", 32'(edit_minutes), 0);
    chk("rst_edit_s", 32'(edit_seconds), 0);
    chk("rst_stb", 32'(load_stb), 0);
    chk("rst_load_h", 32'(load_hours), 0);
    chk("rst_load_m", 32'(load_minutes), 0);
    chk("rst_load_s", 32'(load_seconds), 0);
    step(3);
    rst = 1'b0;
    step(12);
    chk("idle_field", 32'(edit_field), 0);

    // glitch rejection
    btn_mode = 1'b1;
    step(3);
    btn_mode = 1'b0;
    step(20);
    chk("glitch_field", 32'(edit_field), 0);
    chk("glitch_hold", 32'(hold), 0);

    // clean press: takes effect 7 edges after the raw edge
    btn_mode = 1'b1;
    step(6);
    chk("press_early_field", 32'(edit_field), 0);
    step(1);
    chk("press_field", 32'(edit_field), 1);
    chk("press_hold", 32'(hold), 1);
    chk("snap_h", 32'(edit_hours), 12);
    chk("snap_m", 32'(edit_minutes), 34);
    chk("snap_s", 32'(edit_seconds), 56);
    step(3);
    btn_mode = 1'b0;
    step(10);

    // edit and commit 14:33:56
    press(0, 1, 0);
    press(0, 1, 0);
    chk("up2_h", 32'(edit_hours), 14);
    press(1, 0, 0);
    chk("field_m", 32'(edit_field), 2);
    press(0, 0, 1);
    chk("down_m", 32'(edit_minutes), 33);
    press(1, 0, 0);
    chk("field_s", 32'(edit_field), 3);
    q.push_back('{14, 33, 56});
    press(1, 0, 0);
    chk("stb_count1", n_stb, 1);
    chk("post_commit_hold", 32'(hold), 0);
    chk("post_commit_field", 32'(edit_field), 0);
    chk("post_commit_stb", 32'(load_stb), 0);
    chk("kept_load_h", 32'(load_hours), 14);

    // wrap-around
    set_curr(23, 0, 59);
    press(1, 0, 0);
    chk("wrap_snap_h", 32'(edit_hours), 23);
    press(0, 1, 0);
    chk("wrap_h_up", 32'(edit_hours), 0);
    press(0, 0, 1);
    chk("wrap_h_dn", 32'(edit_hours), 23);
    press(1, 0, 0);
    press(0, 0, 1);
    chk("wrap_m_dn", 32'(edit_minutes), 59);
    press(1, 0, 0);
    press(0, 1, 0);
    chk("wrap_s_up", 32'(edit_seconds), 0);
    q.push_back('{23, 59, 0});
    press(1, 0, 0);
    chk("stb_count2", n_stb, 2);

    // auto-repeat: press + 6 repeats
    set_curr(5, 10, 20);
    press(1, 0, 0);
    press(1, 0, 0);
    chk("rep_start_m", 32'(edit_minutes), 10);
    btn_up = 1'b1;
    step(48);
    btn_up = 1'b0;
    step(15);
    chk("rep_m", 32'(edit_minutes), 17);
    press(1, 0, 0);
    q.push_back('{5, 17, 20});
    press(1, 0, 0);
    chk("stb_count3", n_stb, 3);

    // simultaneity and timeout
    set_curr(8, 8, 8);
    press(1, 0, 0);
    press(0, 1, 1);
    chk("updown_h", 32'(edit_hours), 8);
    press(1, 1, 0);
    chk("mode_wins_field", 32'(edit_field), 2);
    chk("mode_wins_h", 32'(edit_hours), 8);
    press(1, 0, 0);
    chk("to_enter_field", 32'(edit_field), 3);
    step(150);
    chk("to_early_field", 32'(edit_field), 3);
    chk("to_early_hold", 32'(hold), 1);
    step(50);
    chk("to_field", 32'(edit_field), 0);
    chk("to_hold", 32'(hold), 0);
    chk("to_stb_count", n_stb, 3);

    // reset mid-edit with mode held through reset
    set_curr(1, 2, 3);
    press(1, 0, 0);
    press(1, 0, 0);
    chk("mid_field", 32'(edit_field), 2);
    btn_mode = 1'b1;
    step(3);
    #2 rst = 1'b1;
    #1;
    chk("arst_hold", 32'(hold), 0);
    chk("arst_field", 32'(edit_field), 0);
    chk("arst_stb", 32'(load_stb), 0);
    chk("arst_edit_m", 32'(edit_minutes), 0);
    step(2);
    rst = 1'b0;
    step(30);
    chk("held_no_event", 32'(edit_field), 0);
    btn_mode = 1'b0;
    step(15);
    press(1, 0, 0);
    chk("repress_field", 32'(edit_field), 1);
    chk("repress_hold", 32'(hold), 1);
    chk("final_stb_count", n_stb, 3);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
